xs3_serial_adder: RTL

- Digit-serial adder for two multi-digit excess-3 (XS3) numbers, one digit pair per beat, least-significant digit first.
- Sits directly downstream of the combinational BCD-to-XS3 digit converters, which feed its in_a and in_b.
- Produces XS3 sum digits over a valid/ready stream, plus a final carry digit when needed.
- One pipeline register stage on the output, with a small FSM handling carry flush.

---
 rtl/xs3_serial_adder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/xs3_serial_adder.sv
// Digit-serial excess-3 adder, LSD first, with one registered output stage and carry flush.
// Define XS3_CHECK_EN to build the sticky illegal-code detector driving err.
module xs3_serial_adder #(
    parameter int MAX_DIGITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_first,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_last,
    output logic       ovf,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_t           state_reg, state_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             out_valid_reg, out_valid_next;
    logic [3:0]       out_digit_reg, out_digit_next;
    logic             out_last_reg, out_last_next;
    logic             ovf_reg, ovf_next;

    logic       slot_free;
    logic       accept;
    logic       first_beat;
    logic       cin;
    logic [4:0] sum;
    logic [3:0] digit;
    logic       cout;

    assign slot_free  = !out_valid_reg || out_ready;
    assign in_ready   = (state_reg != FLUSH) && slot_free;
    assign accept     = in_valid && in_ready;
    assign first_beat = in_first || (state_reg == IDLE);
    assign cin        = first_beat ? 1'b0 : carry_reg;
    assign sum        = {1'b0, in_a} + {1'b0, in_b} + {4'b0, cin};
    assign cout       = sum[4];
    // XS3 correction: a binary carry means +3, otherwise remove the doubled bias.
    assign digit      = cout ? (sum[3:0] + 4'd3) : (sum[3:0] - 4'd3);

    always_comb begin
        state_next     = state_reg;
        carry_next     = carry_reg;
        count_next     = count_reg;
        out_valid_next = out_valid_reg;
        out_digit_next = out_digit_reg;
        out_last_next  = out_last_reg;
        ovf_next       = ovf_reg;

        if (out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            FLUSH: begin
                if (slot_free) begin
                    out_valid_next = 1'b1;
                    out_digit_next = 4'h4;
                    out_last_next  = 1'b1;
                    carry_next     = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                if (accept) begin
                    out_valid_next = 1'b1;
                    out_digit_next = digit;
                    out_last_next  = in_last && !cout;
                    carry_next     = cout;
                    if (first_beat) begin
                        count_next = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (count_reg == MAX_CNT) begin
                        ovf_next   = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                    if (in_last) begin
                        state_next = cout ? FLUSH : IDLE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_digit_reg <= 4'h0;
            out_last_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            carry_reg     <= carry_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
            out_digit_reg <= out_digit_next;
            out_last_reg  <= out_last_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_digit = out_digit_reg;
    assign out_last  = out_last_reg;
    assign ovf       = ovf_reg;

`ifdef XS3_CHECK_EN
    logic [3:0] operand [2];
    logic [1:0] bad;
    logic       err_reg;

    assign operand[0] = in_a;
    assign operand[1] = in_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chk
            assign bad[gi] = (operand[gi] < 4'h3) || (operand[gi] > 4'hC);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept && (bad != 2'b00)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif
endmodule
